// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin arbiter that shares one combinational alu
// between NREQ requesters and registers each result into a one-entry output slot.
// Optional feature macro: ALU_ARB_ILLEGAL_OP_EN (flags opcodes that are not legal
// alu codes on rsp_err and forces the result to zero).

// 32-bit alu with 6-bit opcode. flags = {flag, overflow, negative, carry, zero}.
// Only SLT and SLTU drive flag; every other opcode reports 0 there.
module alu (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [5:0]  aluc,
   output logic [31:0] r,
   output logic [4:0]  flags,
   output logic        legal
);
   logic [32:0] sum;
   logic [32:0] dif;
   logic        flag;
   logic        ovf;
   logic        cy;

   assign sum = {1'b0, a} + {1'b0, b};
   assign dif = {1'b0, a} - {1'b0, b};   // bit 32 is the unsigned borrow

   // Opcode decode: shifts take their amount from a[4:0] and shift b
   always_comb begin
      r     = '0;
      flag  = 1'b0;
      ovf   = 1'b0;
      cy    = 1'b0;
      legal = 1'b1;
      case (aluc)
         6'b100000: begin r = sum[31:0]; ovf = (a[31] == b[31]) && (sum[31] != a[31]); end
         6'b100001: begin r = sum[31:0]; cy = sum[32]; end
         6'b100010: begin r = dif[31:0]; ovf = (a[31] != b[31]) && (dif[31] != a[31]); end
         6'b100011: begin r = dif[31:0]; cy = dif[32]; end
         6'b100100: r = a & b;
         6'b100101: r = a | b;
         6'b100110: r = a ^ b;
         6'b100111: r = ~(a | b);
         6'b101010: begin flag = ($signed(a) < $signed(b)); r = {31'b0, flag}; end
         6'b101011: begin flag = (a < b); r = {31'b0, flag}; end
         6'b000000, 6'b000100: r = b << a[4:0];
         6'b000010, 6'b000110: r = b >> a[4:0];
         6'b000011, 6'b000111: r = $signed(b) >>> a[4:0];
         6'b001111: r = {a[15:0], 16'h0000};
         default:   legal = 1'b0;
      endcase
   end

   assign flags = {flag, ovf, r[31], cy, (r == 32'd0)};
endmodule

module alu_issue_arbiter #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*32-1:0] req_a,
   input  logic [NREQ*32-1:0] req_b,
   input  logic [NREQ*6-1:0]  req_aluc,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [ID_W-1:0]    rsp_id,
   output logic [31:0]        rsp_r,
   output logic [4:0]         rsp_flags,
   output logic               rsp_err
);
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] gidx;
   logic            found;
   logic            slot_free;
   int              idx;
   logic [31:0]     sel_a;
   logic [31:0]     sel_b;
   logic [5:0]      sel_c;
   logic [31:0]     alu_r;
   logic [4:0]      alu_f;
   logic            alu_legal;
   logic [31:0]     r_d;
   logic [4:0]      f_d;
   logic            err_d;

   // A draining slot counts as free so it can be refilled in the same cycle
   assign slot_free = !rsp_valid || rsp_ready;

   // Rotating-priority search starting at ptr; depends only on handshake state
   always_comb begin
      found = 1'b0;
      gidx  = '0;
      idx   = 0;
      if (slot_free && !rst) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[ID_W'(idx)]) begin
               found = 1'b1;
               gidx  = ID_W'(idx);
            end
         end
      end
   end

   // One-hot grant from the search result
   always_comb begin
      req_ready = '0;
      if (found) req_ready[gidx] = 1'b1;
   end

   assign sel_a = req_a[32*gidx +: 32];
   assign sel_b = req_b[32*gidx +: 32];
   assign sel_c = req_aluc[6*gidx +: 6];

   alu u_alu (
      .a     (sel_a),
      .b     (sel_b),
      .aluc  (sel_c),
      .r     (alu_r),
      .flags (alu_f),
      .legal (alu_legal)
   );

   // Slot data for the granted op, with optional illegal-opcode override
   always_comb begin
      r_d   = alu_r;
      f_d   = alu_f;
      err_d = 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
      if (!alu_legal) begin
         r_d   = '0;
         f_d   = 5'b00001;
         err_d = 1'b1;
      end
`endif
   end

   // Output slot and round-robin pointer; data holds on drain and backpressure
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_r     <= '0;
         rsp_flags <= '0;
         rsp_err   <= 1'b0;
         ptr       <= '0;
      end else if (found) begin
         rsp_valid <= 1'b1;
         rsp_id    <= gidx;
         rsp_r     <= r_d;
         rsp_flags <= f_d;
         rsp_err   <= err_d;
         ptr       <= (gidx == ID_W'(NREQ-1)) ? '0 : gidx + 1'b1;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   // Only consulted when the illegal-opcode feature is compiled in
   logic unused_legal;
   assign unused_legal = alu_legal;
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Randomised bench for alu_issue_arbiter with an in-bench reference model:
// grant search over a requester table plus an integer-arithmetic alu model.
module tb_alu_issue_arbiter;
   localparam int NREQ = 4;
   localparam int ID_W = 2;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*32-1:0] req_a = '0;
   logic [NREQ*32-1:0] req_b = '0;
   logic [NREQ*6-1:0]  req_aluc = '0;
   logic               rsp_valid;
   logic               rsp_ready = 1'b0;
   logic [ID_W-1:0]    rsp_id;
   logic [31:0]        rsp_r;
   logic [4:0]         rsp_flags;
   logic               rsp_err;

   always #5 clk = ~clk;

   alu_issue_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_aluc(req_aluc),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
   );

   int vecs = 0;
   int errs = 0;

   // reference model state
   int          m_ptr;
   bit          m_v;
   int          m_id;
   logic [31:0] m_r;
   logic [4:0]  m_f;
   bit          m_e;
   bit          pv [NREQ];
   logic [31:0] pa [NREQ];
   logic [31:0] pb [NREQ];
   logic [5:0]  pc [NREQ];

   logic [5:0] legal_ops [17] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                  6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                                  6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110,
                                  6'b000111, 6'b001111};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [5:0] c,
                                   output logic [31:0] r, output logic [4:0] f, output bit e);
      longint ua, ub, sa, sb, res;
      bit flag, ov, cy, legal;
      int sh;
      ua = longint'(a); ub = longint'(b);
      sa = longint'($signed(a)); sb = longint'($signed(b));
      sh = int'(a[4:0]);
      res = 0; flag = 0; ov = 0; cy = 0; legal = 1;
      case (c)
         6'b100000: begin res = sa + sb; ov = (res > 64'sd2147483647) || (res < -64'sd2147483648); end
         6'b100001: begin res = ua + ub; cy = (res >= 64'sd4294967296); end
         6'b100010: begin res = sa - sb; ov = (res > 64'sd2147483647) || (res < -64'sd2147483648); end
         6'b100011: begin res = ua - ub; cy = (ua < ub); end
         6'b100100: res = ua & ub;
         6'b100101: res = ua | ub;
         6'b100110: res = ua ^ ub;
         6'b100111: res = ~(ua | ub);
         6'b101010: begin flag = (sa < sb); res = flag; end
         6'b101011: begin flag = (ua < ub); res = flag; end
         6'b000000, 6'b000100: res = ub << sh;
         6'b000010, 6'b000110: res = ub >> sh;
         6'b000011, 6'b000111: res = sb >>> sh;
         6'b001111: res = (ua & 64'hFFFF) * 65536;
         default:   legal = 0;
      endcase
      r = res[31:0];
      f = {flag, ov, r[31], cy, (r == 0)};
`ifdef ALU_ARB_ILLEGAL_OP_EN
      e = !legal;
`else
      e = 0;
`endif
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_v = 0; m_id = 0; m_r = '0; m_f = '0; m_e = 0;
      for (int i = 0; i < NREQ; i++) pv[i] = 0;
   endtask

   // reset with every requester valid; grants must stay off throughout
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1 chk("rst_req_ready", req_ready, 0);
         @(posedge clk); #1 chk("rst_rsp_valid", rsp_valid, 0);
         @(negedge clk);
      end
      rst = 1'b0;
      model_reset();
      chk("rst_id", rsp_id, 0);
      chk("rst_r", rsp_r, 0);
      chk("rst_flags", rsp_flags, 0);
      chk("rst_err", rsp_err, 0);
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [5:0] c);
      pv[i] = 1; pa[i] = a; pb[i] = b; pc[i] = c;
   endtask

   // one cycle: drive requester table, check grant, then check slot after the edge
   task automatic step(input bit rdy);
      int g;
      int idx;
      logic [NREQ-1:0] eg;
      @(negedge clk);
      rsp_ready = rdy;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]          = pv[i];
         req_a[32*i +: 32]     = pa[i];
         req_b[32*i +: 32]     = pb[i];
         req_aluc[6*i +: 6]    = pc[i];
      end
      #1;
      g = -1;
      if (!m_v || rdy)
         for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && pv[idx]) g = idx;
         end
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      chk("req_ready", req_ready, eg);
      @(posedge clk); #1;
      if (g >= 0) begin
         ref_alu(pa[g], pb[g], pc[g], m_r, m_f, m_e);
         m_v = 1; m_id = g; m_ptr = (g + 1) % NREQ; pv[g] = 0;
      end else if (rdy) begin
         m_v = 0;
      end
      chk("rsp_valid", rsp_valid, m_v);
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_r", rsp_r, m_r);
      chk("rsp_flags", rsp_flags, m_f);
      chk("rsp_err", rsp_err, m_e);
   endtask

   initial begin
      int prev;
      for (int i = 0; i < NREQ; i++) begin pa[i] = '0; pb[i] = '0; pc[i] = '0; end
      do_reset();

      // single ADD on requester 0 (ptr is 0 after reset, so all-valid would also pick 0)
      set_op(0, 32'd5, 32'd3, 6'b100000);
      step(1);
      chk("add_valid", rsp_valid, 1);
      chk("add_id", rsp_id, 0);
      chk("add_r", rsp_r, 32'd8);
      chk("add_flags", rsp_flags, 0);

      // round robin with all four continuously valid
      prev = int'(rsp_id);
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < NREQ; i++) set_op(i, 32'(i), 32'd100, 6'b100001);
         step(1);
         chk("rr_seq", rsp_id, (prev + 1) % NREQ);
         prev = int'(rsp_id);
      end
      for (int i = 0; i < NREQ; i++) pv[i] = 0;

      // backpressure: slot full, req1 SUB pending, no grant for 3 cycles
      set_op(1, 32'd1, 32'd2, 6'b100010);
      for (int c = 0; c < 3; c++) step(0);
      step(1);
      chk("sub_r", rsp_r, 32'hFFFFFFFF);
      chk("sub_neg", rsp_flags[2], 1);
      for (int c = 0; c < 3; c++) step(0);
      chk("sub_hold", rsp_r, 32'hFFFFFFFF);

      set_op(2, 32'hFFFFFFFF, 32'd0, 6'b101010);
      step(1);
      chk("slt_r", rsp_r, 32'd1);
      chk("slt_flag", rsp_flags[4], 1);

      set_op(3, 32'h00001234, 32'd0, 6'b001111);
      step(1);
      chk("lui_r", rsp_r, 32'h12340000);

      set_op(0, 32'h12345678, 32'h9ABCDEF0, 6'b111111);
      step(1);
`ifdef ALU_ARB_ILLEGAL_OP_EN
      chk("illegal_err", rsp_err, 1);
      chk("illegal_flags", rsp_flags, 5'b00001);
`else
      chk("illegal_err", rsp_err, 0);
`endif
      chk("illegal_r", rsp_r, 0);

      // reset while the slot is full
      set_op(1, 32'd7, 32'd9, 6'b100001);
      step(0);
      do_reset();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pv[i] && $urandom_range(0, 2) == 0) begin
               logic [5:0] op;
               if ($urandom_range(0, 9) == 0) op = 6'($urandom);
               else op = legal_ops[$urandom_range(0, 16)];
               set_op(i, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom, op);
            end else if (pv[i] && $urandom_range(0, 15) == 0) begin
               pv[i] = 0;
            end
         end
         step($urandom_range(0, 3) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
